// File: rtl/sha_pkg.sv
// Shared SHA-256 types, round constants, initial hash value and the
// boolean/sigma helper functions used by the compression datapath.
package sha_pkg;

  typedef logic [31:0]      word_t;
  typedef logic [7:0][31:0] hash_t;   // index 0 = a / H0

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } state_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic hash_t iv_hash();
    hash_t v;
    for (int i = 0; i < 8; i++) v[i] = IV[i];
    return v;
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Rotations written as concatenations so they stay fixed wiring
  function automatic word_t bsig0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t bsig1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

endpackage

// File: rtl/sha_round.sv
// One combinational SHA-256 round: working state a..h plus K[t], w[t] in,
// next a..h out. Kept standalone so it can be chained for unrolling.
module sha_round
  import sha_pkg::*;
(
  input  hash_t st_i,
  input  word_t k_i,
  input  word_t w_i,
  output hash_t st_o
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = st_i[7] + bsig1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
    t2 = bsig0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);

    st_o[0] = t1 + t2;
    st_o[1] = st_i[0];
    st_o[2] = st_i[1];
    st_o[3] = st_i[2];
    st_o[4] = st_i[3] + t1;
    st_o[5] = st_i[4];
    st_o[6] = st_i[5];
    st_o[7] = st_i[6];
  end

endmodule

// File: rtl/sha_compress.sv
// Iterative SHA-256 compression, one round per clock, 66 cycles per block.
// Optional macro SHA_COMPRESS_CHAIN_EN adds the 'first' port for multi-block chaining.
module sha_compress
  import sha_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef SHA_COMPRESS_CHAIN_EN
  input  logic              first,
`endif
  input  logic [63:0][31:0] w,
  output logic              busy,
  output logic              valid,
  output logic [7:0][31:0]  digest
);

  localparam int TW = $clog2(NUM_ROUNDS);
  localparam logic [TW-1:0] LAST_T = TW'(NUM_ROUNDS - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  hash_t         work_q, work_d;
  hash_t         hbase_q, hbase_d;
  hash_t         digest_q, digest_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  hash_t         seed;
  hash_t         round_nxt;

`ifdef SHA_COMPRESS_CHAIN_EN
  assign seed = first ? iv_hash() : digest_q;
`else
  assign seed = iv_hash();
`endif

  sha_round u_round (
    .st_i (work_q),
    .k_i  (K[t_q]),
    .w_i  (w[t_q]),
    .st_o (round_nxt)
  );

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    work_d   = work_q;
    hbase_d  = hbase_q;
    digest_d = digest_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = seed;
          hbase_d = seed;
          t_d     = '0;
          busy_d  = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        work_d = round_nxt;
        t_d    = t_q + TW'(1);
        if (t_q == LAST_T) state_d = FINAL;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) digest_d[i] = hbase_q[i] + work_q[i];
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      t_q      <= '0;
      work_q   <= '0;
      hbase_q  <= '0;
      digest_q <= iv_hash();
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      work_q   <= work_d;
      hbase_q  <= hbase_d;
      digest_q <= digest_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign digest = digest_q;

`ifndef SYNTHESIS
  // The schedule is read live every round, so it must not move mid-block
  w_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ROUND) |-> $stable(w));
`endif

endmodule

// File: tb/tb_sha_compress.sv
// Scoreboard bench for sha_compress: builds message schedules from padded
// blocks, queues expected digests and arrival cycles, compares on valid.
module tb_sha_compress;

  localparam logic [255:0] IVV   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
`ifdef SHA_COMPRESS_CHAIN_EN
  logic              first = 1'b1;
`endif
  logic [63:0][31:0] w = '0;
  logic              busy;
  logic              valid;
  logic [7:0][31:0]  digest;

  typedef struct {
    logic [255:0] dig;
    bit           chk;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_v = 1'b0;

  logic [31:0] m_abc [16];
  logic [31:0] m_emp [16];
  logic [31:0] m_b1  [16];
  logic [31:0] m_b2  [16];

  sha_compress #(.NUM_ROUNDS(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
`ifdef SHA_COMPRESS_CHAIN_EN
    .first  (first),
`endif
    .w      (w),
    .busy   (busy),
    .valid  (valid),
    .digest (digest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] flat(input logic [7:0][31:0] d);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[255-32*i -: 32] = d[i];
    return v;
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0][31:0] expand(input logic [31:0] m [16]);
    logic [31:0]       s [64];
    logic [63:0][31:0] r;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) s[i] = m[i];
      else        s[i] = ss1(s[i-2]) + s[i-7] + ss0(s[i-15]) + s[i-16];
      r[i] = s[i];
    end
    return r;
  endfunction

  // Called on a falling edge; start is taken on the next rising edge
  task automatic run_block(input logic [31:0] m [16], input logic [255:0] dig, input bit chk);
    w     = expand(m);
    start = 1'b1;
    sb.push_back('{dig: dig, chk: chk, due: cyc + 66});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (valid) break;
    end
    check("valid_seen", valid, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      check("valid_width", prev_v, 1'b0);
      check("sb_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("latency", cyc, mon_e.due);
        if (mon_e.chk) check("digest", flat(digest), mon_e.dig);
      end
    end
    prev_v <= valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_abc[i] = '0; m_emp[i] = '0; m_b1[i] = '0; m_b2[i] = '0;
    end
    m_abc[0]  = 32'h61626380;
    m_abc[15] = 32'h00000018;
    m_emp[0]  = 32'h80000000;
    m_b1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
             32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
             32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
             32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    m_b2[15]  = 32'h000001c0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_digest", flat(digest), IVV);
    rst_n = 1'b1;
    @(negedge clk);

    run_block(m_abc, ABC, 1'b1);
    check("busy_run", busy, 1'b1);
    wait_done(200);

    run_block(m_emp, EMPTY, 1'b1);
    wait_done(200);
    repeat (5) @(negedge clk);
    check("digest_hold", flat(digest), EMPTY);

    // Back-to-back: second start issued in the valid cycle
`ifdef SHA_COMPRESS_CHAIN_EN
    first = 1'b1;
    run_block(m_b1, '0, 1'b0);
    wait_valid(100);
    first = 1'b0;
    run_block(m_b2, TWO, 1'b1);
    first = 1'b1;
`else
    run_block(m_abc, ABC, 1'b1);
    wait_valid(100);
    run_block(m_emp, EMPTY, 1'b1);
`endif
    wait_done(200);

    // start during round 10 must be ignored
    run_block(m_abc, ABC, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    repeat (80) @(negedge clk);
    check("single_valid_idle", busy, 1'b0);

    // Asynchronous reset around round 30
    run_block(m_emp, EMPTY, 1'b1);
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", valid, 1'b0);
    check("abort_digest", flat(digest), IVV);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block(m_abc, ABC, 1'b1);
    wait_done(200);
    check("final_digest", flat(digest), ABC);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
